operand_fetch: RTL and testbench

Operand sequencer feeding the arithmetic/logic stage: walks the operand ROM in pairs and presents a stable `OpA`/`OpB` pair to the downstream logic block on the DE10-Lite. A debounced push-button (KEY) advances to the next pair. Each pair is fetched over two synchronous ROM reads and committed to both operand outputs in the same cycle, so downstream never sees a half-updated pair.

---
 rtl/opfetch_pkg.sv | 16 +
 rtl/key_debounce.sv | 52 +++++
 rtl/operand_fetch.sv | 156 +++++++++++++++
 tb/tb_operand_fetch.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opfetch_pkg.sv
// Shared types for the operand sequencer: fetch FSM states and the ROM pair layout.
package opfetch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET_A  = 3'd1,
    WAIT_A = 3'd2,
    SET_B  = 3'd3,
    WAIT_B = 3'd4
  } fetch_state_t;

  // Pair p lives at {p, OPA_OFFSET} and {p, OPB_OFFSET}.
  localparam logic OPA_OFFSET = 1'b0;
  localparam logic OPB_OFFSET = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, and a one-cycle
// press pulse on an accepted high-to-low transition of the active-low key.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic [CNT_W-1:0] cnt_r;
  logic             press_r;

  // Synchronize, time the stable interval, and accept the new level once it has held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      level_r <= 1'b1;
      cnt_r   <= '0;
      press_r <= 1'b0;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      // sync1 != sync2 means the synchronized level changes on this edge.
      if (sync1_r != sync2_r) begin
        cnt_r <= '0;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if ((cnt_r == CNT_MAX) && (sync2_r != level_r)) begin
        level_r <= sync2_r;
        press_r <= ~sync2_r;
      end else begin
        level_r <= level_r;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/operand_fetch.sv
// Operand pair sequencer: two ROM reads per pair, committed to OpA/OpB together.
// Optional auto-stepping timer is enabled with the OPFETCH_AUTO_EN macro.
module operand_fetch
  import opfetch_pkg::*;
#(
  parameter int ADDR_W          = 4,
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 500000
`ifdef OPFETCH_AUTO_EN
  ,
  parameter int AUTO_PERIOD     = 50000000
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] OpA,
  output logic [DATA_W-1:0] OpB,
  output logic              operand_valid,
  output logic [ADDR_W-2:0] pair_index
`ifdef OPFETCH_AUTO_EN
  ,
  input  logic              auto_run
`endif
);

  localparam int PAIR_W = ADDR_W - 1;

  fetch_state_t      state_r;
  fetch_state_t      state_next;
  logic [PAIR_W-1:0] pair_r;
  logic [PAIR_W-1:0] pair_next;
  logic              pending_r;
  logic              pending_next;
  logic              init_r;
  logic              trigger;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] shadow_r;
  logic [DATA_W-1:0] opa_r;
  logic [DATA_W-1:0] opb_r;
  logic              valid_r;
  logic              key_press;
  logic              step_req;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk   (clk),
    .reset (reset),
    .key_n (step_n),
    .press (key_press)
  );

`ifdef OPFETCH_AUTO_EN
  localparam int AUTO_W = $clog2(AUTO_PERIOD + 1);
  logic [AUTO_W-1:0] auto_cnt_r;
  logic              auto_req_r;

  // Periodic step request while auto_run is held; idles at zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_cnt_r <= '0;
      auto_req_r <= 1'b0;
    end else if (!auto_run) begin
      auto_cnt_r <= '0;
      auto_req_r <= 1'b0;
    end else if (auto_cnt_r == AUTO_W'(AUTO_PERIOD - 1)) begin
      auto_cnt_r <= '0;
      auto_req_r <= 1'b1;
    end else begin
      auto_cnt_r <= auto_cnt_r + AUTO_W'(1);
      auto_req_r <= 1'b0;
    end
  end

  assign step_req = key_press | auto_req_r;
`else
  assign step_req = key_press;
`endif

  // Next-state, trigger and one-deep pending request bookkeeping.
  always_comb begin
    state_next   = state_r;
    pair_next    = pair_r;
    pending_next = pending_r | step_req;
    trigger      = 1'b0;
    case (state_r)
      IDLE: begin
        if (init_r || pending_r || step_req) begin
          trigger    = 1'b1;
          state_next = SET_A;
          // The post-reset fetch shows pair 0; every later trigger advances.
          if (init_r) begin
            pair_next    = pair_r;
            pending_next = pending_r | step_req;
          end else if (pending_r) begin
            pair_next    = pair_r + PAIR_W'(1);
            pending_next = step_req;
          end else begin
            pair_next    = pair_r + PAIR_W'(1);
            pending_next = 1'b0;
          end
        end else begin
          state_next = IDLE;
        end
      end
      SET_A:   state_next = WAIT_A;
      WAIT_A:  state_next = SET_B;
      SET_B:   state_next = WAIT_B;
      WAIT_B:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, address, shadow and committed operand registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      pair_r    <= '0;
      pending_r <= 1'b0;
      init_r    <= 1'b1;
      addr_r    <= '0;
      shadow_r  <= '0;
      opa_r     <= '0;
      opb_r     <= '0;
      valid_r   <= 1'b0;
    end else begin
      state_r   <= state_next;
      pair_r    <= pair_next;
      pending_r <= pending_next;
      if (trigger) begin
        init_r  <= 1'b0;
        addr_r  <= {pair_next, OPA_OFFSET};
        valid_r <= 1'b0;
      end else if (state_r == WAIT_A) begin
        shadow_r <= rom_data;
        addr_r   <= {pair_r, OPB_OFFSET};
      end else if (state_r == WAIT_B) begin
        opa_r   <= shadow_r;
        opb_r   <= rom_data;
        valid_r <= 1'b1;
      end else begin
        addr_r <= addr_r;
      end
    end
  end

  assign rom_addr      = addr_r;
  assign OpA           = opa_r;
  assign OpB           = opb_r;
  assign operand_valid = valid_r;
  assign pair_index    = pair_r;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: behavioural ROM, commit scoreboard, scenario tasks.
module tb_operand_fetch;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       step_n = 1'b1;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] OpA;
  logic [7:0] OpB;
  logic       operand_valid;
  logic [2:0] pair_index;

  int checks = 0;
  int failures = 0;
  int cur_pair = 0;

  typedef struct packed {
    logic [2:0] pair;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] rom [16];

  logic       valid_d = 1'b0;
  logic       reset_d = 1'b1;
  logic [7:0] opa_d = 8'h00;
  logic [7:0] opb_d = 8'h00;

  localparam logic [63:0] CLEAN  = 64'hFFFF_FFFF_FFFF_FC00;
  localparam logic [63:0] BOUNCE = 64'hFFFF_FFFF_FFC0_0E38;

  always #5 clk = ~clk;

  operand_fetch #(
    .ADDR_W(4),
    .DATA_W(8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .step_n(step_n),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .OpA(OpA),
    .OpB(OpB),
    .operand_valid(operand_valid),
    .pair_index(pair_index)
  );

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h40 + 8'(i);
    rom[0]  = 8'h3C;
    rom[1]  = 8'hA5;
    rom[2]  = 8'h0F;
    rom[3]  = 8'hF0;
    rom[14] = 8'h11;
    rom[15] = 8'h22;
  end

  // Synchronous ROM: data reflects the address sampled on the previous edge.
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic exp_t pair_exp(input int p);
    exp_t e;
    e.pair = 3'(p);
    e.a    = rom[2 * p];
    e.b    = rom[2 * p + 1];
    return e;
  endfunction

  // Scoreboard: every rising operand_valid must match the oldest expected pair.
  always @(negedge clk) begin
    if (!reset && operand_valid && !valid_d) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL commit_unexpected pair=%0d A=%h B=%h", pair_index, OpA, OpB);
      end else begin
        mon_e = sb.pop_front();
        if ({pair_index, OpA, OpB} !== {mon_e.pair, mon_e.a, mon_e.b}) begin
          failures++;
          $display("FAIL commit got pair=%0d A=%h B=%h expected pair=%0d A=%h B=%h",
                   pair_index, OpA, OpB, mon_e.pair, mon_e.a, mon_e.b);
        end
      end
    end
    if (!reset && !reset_d && ((OpA !== opa_d) || (OpB !== opb_d))) begin
      checks++;
      if (!(operand_valid && !valid_d)) begin
        failures++;
        $display("FAIL op_change_outside_commit A=%h B=%h valid=%b prev_valid=%b",
                 OpA, OpB, operand_valid, valid_d);
      end
    end
    valid_d = operand_valid;
    opa_d   = OpA;
    opb_d   = OpB;
    reset_d = reset;
  end

  task automatic key_wave(input logic [63:0] pat, output int falls, output int low_len,
                          output logic [3:0] first_addr, output logic [2:0] first_pair);
    logic prev;
    prev = operand_valid;
    falls = 0;
    low_len = 0;
    first_addr = 4'h0;
    first_pair = 3'h0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!operand_valid) begin
        low_len++;
        if (prev) begin
          falls++;
          if (falls == 1) begin
            first_addr = rom_addr;
            first_pair = pair_index;
          end
        end
      end
      prev = operand_valid;
      step_n = pat[i];
    end
  endtask

  task automatic test_reset;
    logic [3:0] ea [4];
    ea = '{4'd0, 4'd0, 4'd1, 4'd1};
    reset = 1'b1;
    step_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({OpA, OpB, operand_valid, rom_addr, pair_index} !== {8'h00, 8'h00, 1'b0, 4'h0, 3'h0}) begin
      failures++;
      $display("FAIL reset_state got A=%h B=%h valid=%b addr=%0d pair=%0d expected all zero",
               OpA, OpB, operand_valid, rom_addr, pair_index);
    end
    sb.push_back(pair_exp(0));
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({rom_addr, operand_valid} !== {ea[i], 1'b0}) begin
        failures++;
        $display("FAIL reset_fetch_seq cycle=%0d got addr=%0d valid=%b expected addr=%0d valid=0",
                 i, rom_addr, operand_valid, ea[i]);
      end
    end
    @(negedge clk);
    checks++;
    if ({operand_valid, OpA, OpB} !== {1'b1, 8'h3C, 8'hA5}) begin
      failures++;
      $display("FAIL reset_commit got valid=%b A=%h B=%h expected valid=1 A=3c B=a5",
               operand_valid, OpA, OpB);
    end
    cur_pair = 0;
  endtask

  task automatic test_clean_press;
    int f, l;
    logic [3:0] a;
    logic [2:0] p;
    sb.push_back(pair_exp((cur_pair + 1) % 8));
    key_wave(CLEAN, f, l, a, p);
    cur_pair = (cur_pair + 1) % 8;
    checks++;
    if (f != 1 || l != 4) begin
      failures++;
      $display("FAIL clean_valid_low got falls=%0d low_cycles=%0d expected falls=1 low_cycles=4", f, l);
    end
    checks++;
    if ({a, p} !== {3'(cur_pair), 1'b0, 3'(cur_pair)}) begin
      failures++;
      $display("FAIL clean_first_addr got addr=%0d pair=%0d expected addr=%0d pair=%0d",
               a, p, 2 * cur_pair, cur_pair);
    end
    checks++;
    if ({OpA, OpB} !== {8'h0F, 8'hF0}) begin
      failures++;
      $display("FAIL clean_operands got A=%h B=%h expected A=0f B=f0", OpA, OpB);
    end
  endtask

  task automatic test_bounce;
    int f, l;
    logic [3:0] a;
    logic [2:0] p;
    sb.push_back(pair_exp((cur_pair + 1) % 8));
    key_wave(BOUNCE, f, l, a, p);
    cur_pair = (cur_pair + 1) % 8;
    checks++;
    if (f != 1 || pair_index !== 3'(cur_pair)) begin
      failures++;
      $display("FAIL bounce_single_step got falls=%0d pair=%0d expected falls=1 pair=%0d",
               f, pair_index, cur_pair);
    end
  endtask

  task automatic test_wrap;
    int f, l;
    logic [3:0] a;
    logic [2:0] p;
    while (cur_pair != 7) begin
      sb.push_back(pair_exp((cur_pair + 1) % 8));
      key_wave(CLEAN, f, l, a, p);
      cur_pair = (cur_pair + 1) % 8;
      checks++;
      if (f != 1 || pair_index !== 3'(cur_pair)) begin
        failures++;
        $display("FAIL step_pair got falls=%0d pair=%0d expected falls=1 pair=%0d",
                 f, pair_index, cur_pair);
      end
    end
    checks++;
    if ({OpA, OpB} !== {8'h11, 8'h22}) begin
      failures++;
      $display("FAIL pair7_operands got A=%h B=%h expected A=11 B=22", OpA, OpB);
    end
    sb.push_back(pair_exp(0));
    key_wave(CLEAN, f, l, a, p);
    cur_pair = 0;
    checks++;
    if ({f == 1, pair_index, OpA, OpB} !== {1'b1, 3'd0, 8'h3C, 8'hA5}) begin
      failures++;
      $display("FAIL wrap got falls=%0d pair=%0d A=%h B=%h expected falls=1 pair=0 A=3c B=a5",
               f, pair_index, OpA, OpB);
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] got, want;
    sb.push_back(pair_exp((cur_pair + 1) % 8));
    sb.push_back(pair_exp((cur_pair + 2) % 8));
    @(negedge clk);
    force dut.key_press = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      got[i]  = operand_valid;
      want[i] = (i == 4) || (i >= 9);
      if (i == 2) release dut.key_press;
    end
    cur_pair = (cur_pair + 2) % 8;
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL back_to_back_valid got %b expected %b (bit0 first)", got, want);
    end
    checks++;
    if (pair_index !== 3'(cur_pair)) begin
      failures++;
      $display("FAIL back_to_back_pair got %0d expected %0d", pair_index, cur_pair);
    end
  endtask

  task automatic test_reset_mid_fetch;
    logic [15:0] got, want;
    @(negedge clk);
    force dut.key_press = 1'b1;
    @(negedge clk);
    checks++;
    if ({rom_addr, operand_valid} !== {3'(cur_pair + 1), 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midreset_fetch_start got addr=%0d valid=%b expected addr=%0d valid=0",
               rom_addr, operand_valid, 2 * (cur_pair + 1));
    end
    @(negedge clk);
    release dut.key_press;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({OpA, OpB, operand_valid, rom_addr, pair_index} !== {8'h00, 8'h00, 1'b0, 4'h0, 3'h0}) begin
      failures++;
      $display("FAIL midreset_clear got A=%h B=%h valid=%b addr=%0d pair=%0d expected all zero",
               OpA, OpB, operand_valid, rom_addr, pair_index);
    end
    repeat (2) @(negedge clk);
    sb.push_back(pair_exp(0));
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      got[i]  = operand_valid;
      want[i] = (i >= 4);
    end
    cur_pair = 0;
    checks++;
    if (got !== want || pair_index !== 3'd0) begin
      failures++;
      $display("FAIL midreset_refetch got valid=%b pair=%0d expected valid=%b pair=0",
               got, pair_index, want);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_wrap();
    test_back_to_back();
    test_reset_mid_fetch();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got %0d pending entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
